// File: rtl/low_freq_meter.sv
// low_freq_meter: reciprocal frequency meter for low-frequency inputs.
// A start pulse measures one period of signal_in in clk cycles, divides
// CLK_HZ (scaled by powers of ten) by that period to get DIGITS significant
// digits, and converts the quotient to packed BCD for a 7-segment mux.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   start      begin a measurement (sampled only while ready)
//   signal_in  asynchronous input whose frequency is measured
//   ready      high while idle
//   done_tick  one-cycle pulse when the outputs below update
//   bcd_out    packed BCD result, digit 0 in [3:0]
//   scale      digits right of the decimal point (value = bcd / 10^scale Hz)
//   overflow   frequency >= 10^DIGITS Hz
//   timeout    no full period seen within the counter range
module low_freq_meter #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PERIOD_W = 32,
    localparam int unsigned SCALE_W = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signal_in,
    output logic                  ready,
    output logic                  done_tick,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [SCALE_W-1:0]    scale,
    output logic                  overflow,
    output logic                  timeout
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int unsigned NUM_W    = $clog2(longint'(CLK_HZ) * pow10(DIGITS - 1) + 1);
    localparam int unsigned Q_W      = $clog2(pow10(DIGITS));
    localparam int unsigned STEP_MAX = (NUM_W > Q_W) ? NUM_W : Q_W;
    localparam int unsigned STEP_W   = $clog2(STEP_MAX + 1);

    localparam logic [NUM_W-1:0]   N0     = NUM_W'(CLK_HZ);
    localparam logic [NUM_W-1:0]   Q_HI   = NUM_W'(pow10(DIGITS));
    localparam logic [NUM_W-1:0]   Q_LO   = NUM_W'(pow10(DIGITS - 1));
    localparam logic [SCALE_W-1:0] K_MAX  = SCALE_W'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT1, S_MEAS, S_DIV, S_CHECK, S_BCD, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  prev_q;
    logic                  edge_det;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [PERIOD_W-1:0]   p_q, p_d;
    logic [NUM_W-1:0]      n_q, n_d;
    logic [NUM_W-1:0]      q_q, q_d;
    logic [PERIOD_W-1:0]   rem_q, rem_d;
    logic [SCALE_W-1:0]    k_q, k_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic [Q_W-1:0]        bin_q, bin_d;
    logic                  wovf_q, wovf_d;
    logic                  wto_q, wto_d;
    logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
    logic [SCALE_W-1:0]    scale_q, scale_d;
    logic                  overflow_q, overflow_d;
    logic                  timeout_q, timeout_d;
    logic                  done_q, done_d;

    logic [PERIOD_W:0]     trial;
    logic [PERIOD_W:0]     diff;
    logic [NUM_W-1:0]      n10;
    logic [4*DIGITS-1:0]   adj;

    assign edge_det  = sync_q[1] & ~prev_q;
    assign ready     = (state_q == S_IDLE);
    assign done_tick = done_q;
    assign bcd_out   = bcd_out_q;
    assign scale     = scale_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        n_d        = n_q;
        q_d        = q_q;
        rem_d      = rem_q;
        k_d        = k_q;
        step_d     = step_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        wovf_d     = wovf_q;
        wto_d      = wto_q;
        bcd_out_d  = bcd_out_q;
        scale_d    = scale_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        done_d     = 1'b0;

        // Restoring-division step: remainder stays below P, so PERIOD_W+1 bits suffice.
        trial = {rem_q, q_q[NUM_W-1]};
        diff  = trial - {1'b0, p_q};
        n10   = (n_q << 3) + (n_q << 1);
        // Double-dabble correction: add 3 to any BCD digit >= 5 before shifting.
        adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    wovf_d  = 1'b0;
                    wto_d   = 1'b0;
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (cnt_q == '1) begin
                    wto_d   = 1'b1;
                    state_d = S_DONE;
                end else if (edge_det) begin
                    cnt_d   = '0;
                    state_d = S_MEAS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEAS: begin
                if (cnt_q == '1) begin
                    wto_d   = 1'b1;
                    state_d = S_DONE;
                end else if (edge_det) begin
                    p_d     = cnt_q + 1'b1;
                    k_d     = '0;
                    n_d     = N0;
                    q_d     = N0;
                    rem_d   = '0;
                    step_d  = '0;
                    state_d = S_DIV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                if (!diff[PERIOD_W]) begin
                    rem_d = diff[PERIOD_W-1:0];
                    q_d   = {q_q[NUM_W-2:0], 1'b1};
                end else begin
                    rem_d = trial[PERIOD_W-1:0];
                    q_d   = {q_q[NUM_W-2:0], 1'b0};
                end
                if (step_q == STEP_W'(NUM_W - 1)) state_d = S_CHECK;
                else                              step_d  = step_q + 1'b1;
            end
            S_CHECK: begin
                step_d = '0;
                if (q_q >= Q_HI) begin
                    wovf_d  = 1'b1;
                    state_d = S_DONE;
                end else if (q_q < Q_LO && k_q < K_MAX) begin
                    k_d     = k_q + 1'b1;
                    n_d     = n10;
                    q_d     = n10;
                    rem_d   = '0;
                    state_d = S_DIV;
                end else begin
                    bin_d   = q_q[Q_W-1:0];
                    bcd_d   = '0;
                    state_d = S_BCD;
                end
            end
            S_BCD: begin
                bcd_d = {adj[4*DIGITS-2:0], bin_q[Q_W-1]};
                bin_d = bin_q << 1;
                if (step_q == STEP_W'(Q_W - 1)) state_d = S_DONE;
                else                            step_d  = step_q + 1'b1;
            end
            S_DONE: begin
                done_d     = 1'b1;
                overflow_d = wovf_q;
                timeout_d  = wto_q;
                if (wovf_q || wto_q) begin
                    bcd_out_d = '0;
                    scale_d   = '0;
                end else begin
                    bcd_out_d = bcd_q;
                    scale_d   = k_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            p_q        <= '0;
            n_q        <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            step_q     <= '0;
            bcd_q      <= '0;
            bin_q      <= '0;
            wovf_q     <= 1'b0;
            wto_q      <= 1'b0;
            bcd_out_q  <= '0;
            scale_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], signal_in};
            prev_q     <= sync_q[1];
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            n_q        <= n_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            k_q        <= k_d;
            step_q     <= step_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            wovf_q     <= wovf_d;
            wto_q      <= wto_d;
            bcd_out_q  <= bcd_out_d;
            scale_q    <= scale_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_low_freq_meter.sv
// Directed bench for low_freq_meter. CLK_HZ is lowered to 20 kHz so that the
// sub-1 Hz scaling limit, overflow (period of 2 cycles) and long periods all
// fit in a short run; a second instance with a 10-bit period counter covers
// the timeout path.
module tb_low_freq_meter;

    localparam int unsigned CLK_HZ = 20_000;
    localparam int unsigned DIGITS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic        sig = 1'b0;

    logic        ready1, done1, ovf1, to1;
    logic [15:0] bcd1;
    logic [1:0]  scale1;
    logic        ready2, done2, ovf2, to2;
    logic [15:0] bcd2;
    logic [1:0]  scale2;

    int gen_period = 0;
    int errors = 0;
    int checks = 0;

    // Bench model of the held outputs of dut1.
    logic [15:0] exp_bcd1 = '0;
    logic [1:0]  exp_scale1 = '0;
    logic        exp_ovf1 = 1'b0;
    logic        exp_to1 = 1'b0;

    low_freq_meter #(.CLK_HZ(CLK_HZ), .DIGITS(DIGITS), .PERIOD_W(24)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .signal_in(sig),
        .ready(ready1), .done_tick(done1), .bcd_out(bcd1), .scale(scale1),
        .overflow(ovf1), .timeout(to1)
    );

    low_freq_meter #(.CLK_HZ(CLK_HZ), .DIGITS(DIGITS), .PERIOD_W(10)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .signal_in(sig),
        .ready(ready2), .done_tick(done2), .bcd_out(bcd2), .scale(scale2),
        .overflow(ovf2), .timeout(to2)
    );

    always #5 clk = ~clk;

    // Square wave of gen_period cycles; a new nonzero period starts with a rising edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            #2;
            if (gen_period == 0) begin
                sig = 1'b0;
                ph  = 0;
            end else begin
                sig = (ph < gen_period / 2);
                ph  = (ph + 1 >= gen_period) ? 0 : ph + 1;
            end
        end
    end

    task automatic kick(input bit which, input int period);
        gen_period = 0;
        repeat (4) @(negedge clk);
        if (which) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        gen_period = period;
    endtask

    task automatic wait_done(input bit which, input int bound, output bit got);
        got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            @(negedge clk);
            if ((which ? done2 : done1) === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ready1, done1, bcd1, scale1, ovf1, to1} !== {1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected %h", {ready1, done1, bcd1, scale1, ovf1, to1},
                     {1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0});
        end
        checks++;
        if ({ready2, done2, bcd2, scale2, ovf2, to2} !== {1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_dut2: got %h expected %h", {ready2, done2, bcd2, scale2, ovf2, to2},
                     {1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready1 !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: ready got %b expected 1", ready1);
        end
    endtask

    task automatic test_frequencies;
        int          per [5] = '{20, 60, 5000, 40000, 2};
        logic [15:0] eb  [5] = '{16'h1000, 16'h3333, 16'h4000, 16'h0500, 16'h0000};
        logic [1:0]  es  [5] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd0};
        logic        eo  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit got;
        for (int i = 0; i < 5; i++) begin
            kick(1'b0, per[i]);
            // Outputs and flags must hold their previous values while measuring.
            checks++;
            if ({ready1, bcd1, scale1, ovf1, to1} !== {1'b0, exp_bcd1, exp_scale1, exp_ovf1, exp_to1}) begin
                errors++;
                $display("FAIL hold_p%0d: got %h expected %h", per[i], {ready1, bcd1, scale1, ovf1, to1},
                         {1'b0, exp_bcd1, exp_scale1, exp_ovf1, exp_to1});
            end
            wait_done(1'b0, 2 * per[i] + 600, got);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL done_p%0d: done_tick got none expected 1", per[i]);
            end else begin
                checks++;
                if ({bcd1, scale1, ovf1, to1} !== {eb[i], es[i], eo[i], 1'b0}) begin
                    errors++;
                    $display("FAIL result_p%0d: got bcd=%h scale=%0d ovf=%b to=%b expected bcd=%h scale=%0d ovf=%b to=0",
                             per[i], bcd1, scale1, ovf1, to1, eb[i], es[i], eo[i]);
                end
                exp_bcd1   = eb[i];
                exp_scale1 = es[i];
                exp_ovf1   = eo[i];
                exp_to1    = 1'b0;
                @(negedge clk);
                checks++;
                if ({done1, ready1} !== 2'b01) begin
                    errors++;
                    $display("FAIL pulse_p%0d: done,ready got %b expected 01", per[i], {done1, ready1});
                end
            end
        end
    endtask

    task automatic test_flag_clear;
        bit got;
        kick(1'b0, 20);
        checks++;
        if (ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_held_after_start: got %b expected 1", ovf1);
        end
        wait_done(1'b0, 600, got);
        checks++;
        if (!got || {bcd1, scale1, ovf1, to1} !== {16'h1000, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_cleared: got done=%b bcd=%h scale=%0d ovf=%b to=%b expected done=1 bcd=1000 scale=0 ovf=0 to=0",
                     got, bcd1, scale1, ovf1, to1);
        end
        exp_bcd1 = 16'h1000; exp_scale1 = 2'd0; exp_ovf1 = 1'b0; exp_to1 = 1'b0;
    endtask

    task automatic test_start_ignored;
        bit got;
        int pulses;
        kick(1'b0, 60);
        repeat (74) @(negedge clk);
        checks++;
        if (ready1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_div: ready got %b expected 0", ready1);
        end
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        repeat (24) @(negedge clk);
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        wait_done(1'b0, 600, got);
        checks++;
        if (!got || {bcd1, scale1, ovf1, to1} !== {16'h3333, 2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL start_in_div_result: got done=%b bcd=%h scale=%0d expected done=1 bcd=3333 scale=1",
                     got, bcd1, scale1);
        end
        exp_bcd1 = 16'h3333; exp_scale1 = 2'd1;
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            if (done1 === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL no_rerun: extra done pulses %0d ready %b expected 0 pulses ready 1", pulses, ready1);
        end
    endtask

    task automatic test_reset_mid_meas;
        int pulses;
        kick(1'b0, 1000);
        repeat (500) @(negedge clk);
        checks++;
        if (ready1 !== 1'b0) begin
            errors++;
            $display("FAIL busy_in_meas: ready got %b expected 0", ready1);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ready1, done1, bcd1, scale1, ovf1, to1} !== {1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", {ready1, done1, bcd1, scale1, ovf1, to1},
                     {1'b1, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        exp_bcd1 = '0; exp_scale1 = '0; exp_ovf1 = 1'b0; exp_to1 = 1'b0;
        pulses = 0;
        repeat (1500) begin
            @(negedge clk);
            if (done1 === 1'b1) pulses++;
        end
        gen_period = 0;
        checks++;
        if (pulses != 0 || ready1 !== 1'b1 || bcd1 !== 16'h0) begin
            errors++;
            $display("FAIL after_reset_quiet: pulses %0d ready %b bcd %h expected 0 1 0000", pulses, ready1, bcd1);
        end
    endtask

    task automatic test_timeout;
        bit got;
        kick(1'b1, 0);
        repeat (900) @(negedge clk);
        checks++;
        if (ready2 !== 1'b0 || to2 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: ready %b to %b expected 0 0", ready2, to2);
        end
        wait_done(1'b1, 600, got);
        checks++;
        if (!got || {bcd2, scale2, ovf2, to2} !== {16'h0, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_flag: got done=%b bcd=%h scale=%0d ovf=%b to=%b expected done=1 bcd=0000 scale=0 ovf=0 to=1",
                     got, bcd2, scale2, ovf2, to2);
        end
        kick(1'b1, 20);
        wait_done(1'b1, 600, got);
        checks++;
        if (!got || {bcd2, scale2, ovf2, to2} !== {16'h1000, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_cleared: got done=%b bcd=%h scale=%0d ovf=%b to=%b expected done=1 bcd=1000 scale=0 ovf=0 to=0",
                     got, bcd2, scale2, ovf2, to2);
        end
        gen_period = 0;
    endtask

    initial begin
        test_reset;
        test_frequencies;
        test_flag_clear;
        test_start_ignored;
        test_reset_mid_meas;
        test_timeout;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
